shift_adder: RTL and testbench
==============================

# shift_adder

Multi-cycle W-bit adder that splits operands into W/N segments of N bits and registers the carry between segments. Each clock edge moves the carry one segment further. The sum settles to (a+b) mod 2^W after a bounded number of edges with stable operands. It serves as a short-critical-path replacement for a wide combinational adder in accumulators and fast counters, where the caller samples `sum` once every W/N cycles.

## Interface
- `W`, default 16: operand and sum width in bits.
- `N`, default 1: segment width in bits. W must be an integer multiple of N, with N ≥ 1 and N ≤ W. S = W/N is the number of segments.
- `clk` input, 1 bit: the single clock. All registers update on its rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `a` input, W bits: operand A, unsigned.
- `b` input, W bits: operand B, unsigned.
- `sum` output, W bits: segmented sum. This port is combinational from `a`, `b` and the carry registers.
- `valid` output, 1 bit: present only with SHIFT_ADDER_VALID_EN. Asserted when `sum` is the settled result.

## Operation
- Segment k, for k = 0..S-1, covers bits [k·N+N-1 : k·N].
- Carry registers c[0..S-2], one bit each.
- Segment k computes {co_k, sum_k} = a_k + b_k + cin_k. The carry-in cin_0 is 0. For k ≥ 1, cin_k is c[k-1].
- Each edge loads c[k] with co_k for k = 0..S-2. The carry-out of the last segment, co_{S-1}, is discarded, so the result wraps modulo 2^W.
- The `sum` port is the concatenation {sum_{S-1}, …, sum_0}. No register sits on the `sum` path.
- When `rst` is high, all c[k] load 0. Immediately after reset, `sum` equals the segment-wise sum with no inter-segment carries.
- With S = 1 there are no carry registers. `sum` is then a purely combinational a+b, and `rst` has no effect on `sum`.
- Operands are not latched. The caller must hold `a` and `b` stable for the whole settling window. Changing them mid-window restarts settling from the current carry state.
- There are no invalid states. Stale carries are flushed automatically within S-1 edges.

## Timing
- Settling: after the last change of `a` or `b`, or after the release of `rst`, `sum` equals (a+b) mod 2^W after at most S-1 rising edges. It stays correct while the operands are held.
- If no carry crosses a segment boundary, `sum` is correct in the same cycle as the change.
- Accumulator usage: sample `sum` into b once every S cycles. This meets the settling requirement with one cycle of margin.
- Reset mid-settle: carries clear on that edge, and settling restarts from zero carries.
- Critical path: one N-bit adder plus carry-in. It is independent of W.

## Configuration
- SHIFT_ADDER_VALID_EN defined:
  - Adds the `valid` output.
  - Adds registered copies a_q and b_q, reset to 0, plus a saturating counter `cnt` of width ⌈log2 S⌉+1, reset to 0.
  - On each edge, if {a,b} ≠ {a_q,b_q}, then `cnt` loads 0 and a_q/b_q load a/b. Otherwise `cnt` increments and saturates at S-1.
  - `valid` = ({a,b} == {a_q,b_q}) && (`cnt` == S-1). It is combinational and low during reset.
  - `valid` is conservative: it rises at most one cycle after `sum` settles.
- SHIFT_ADDER_VALID_EN undefined: there is no `valid` port and none of the associated registers. The rest of the behaviour is identical.

## Test plan
- W=16, N=1, a=32, b fed back from `sum` every 16 cycles starting at b=0 -> b takes the values 0, 32, 64, 96, …, wrapping to 0 after 2048 sampling periods.
- W=16, N=4, a=16'hFFFF, b=16'h0001 held after reset -> `sum` is 16'hFFF0 at cycle 0 and 16'h0000 by edge 3. With SHIFT_ADDER_VALID_EN, `valid` is 1 once `cnt`=3.
- W=16, N=4, a=16'h1234, b=16'h4321 (no cross-segment carries) -> `sum`=16'h5555 in the same cycle.
- W=16, N=2, random a/b held for 7 edges -> `sum` == (a+b) mod 65536 on every held cycle from edge 7 onward. Repeat for 1000 vectors.
- Reset mid-settle: W=16, N=1, a=16'hFFFF, b=1, assert `rst` at edge 5 -> carries clear. Then `sum` is 16'h0000 by edge 15 after release, and `valid` is 0 until then.
- W=N=8 (S=1), a=200, b=100 -> `sum`=44 combinationally. `rst` has no effect on `sum`.

Source files
------------

// File: rtl/shift_adder.sv
// shift_adder: multi-cycle W-bit adder built from W/N segments of N bits with
// a registered carry between neighbouring segments. Each rising edge moves the
// carry one segment further, so sum settles to (a+b) mod 2^W within S-1 edges.
//
// Ports:
//   clk   - single clock, all registers update on the rising edge
//   rst   - synchronous active-high reset, clears the carry registers
//   a, b  - W-bit unsigned operands, not latched; hold them while settling
//   sum   - W-bit segmented sum, combinational from a, b and the carries
//   valid - settled-result flag, present only when SHIFT_ADDER_VALID_EN is
//           defined (adds operand shadow registers and a settle counter)
module shift_adder #(
  parameter int W = 16,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
`ifdef SHIFT_ADDER_VALID_EN
  ,
  output logic         valid
`endif
);

  localparam int S = W / N;

  genvar k;
  generate
    if (S == 1) begin : g_single
      // A single segment has no carry to propagate: plain combinational add.
      assign sum = a + b;
    end else begin : g_multi
      logic [S-2:0] c_q;
      logic [S-2:0] c_d;
      logic [S-1:0] cin;

      // Segment 0 never receives a carry; segment k takes the carry that
      // segment k-1 produced on the previous edge.
      assign cin = {c_q, 1'b0};

      for (k = 0; k < S; k++) begin : g_seg
        if (k < S - 1) begin : g_mid
          logic [N:0] seg;
          assign seg = {1'b0, a[k*N +: N]} + {1'b0, b[k*N +: N]} + (N+1)'(cin[k]);
          assign sum[k*N +: N] = seg[N-1:0];
          assign c_d[k]        = seg[N];
        end else begin : g_top
          // The top segment's carry-out is dropped, giving the mod 2^W wrap.
          assign sum[k*N +: N] = a[k*N +: N] + b[k*N +: N] + N'(cin[k]);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          c_q <= '0;
        end else begin
          c_q <= c_d;
        end
      end
    end
  endgenerate

`ifdef SHIFT_ADDER_VALID_EN
  localparam int CW = $clog2(S) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(S - 1);

  logic [W-1:0]  a_q;
  logic [W-1:0]  a_d;
  logic [W-1:0]  b_q;
  logic [W-1:0]  b_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          same;

  // Operands unchanged since the last edge; the counter then tracks how many
  // edges the carry chain has had to settle.
  assign same = (a == a_q) && (b == b_q);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (!same) begin
      a_d   = a;
      b_d   = b;
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  // Counting starts one edge after the change, so valid lags settling by at
  // most one cycle; forced low while reset is asserted.
  assign valid = same && (cnt_q == CNT_MAX) && !rst;
`endif

endmodule

// File: tb/tb_shift_adder.sv
module tb_shift_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // W=16, N=1
  logic        rst1;
  logic [15:0] a1, b1, sum1;
  // W=16, N=4
  logic        rst4;
  logic [15:0] a4, b4, sum4;
  // W=16, N=2
  logic        rst2;
  logic [15:0] a2, b2, sum2;
  // W=8, N=8 (single segment)
  logic        rst8;
  logic [7:0]  a8, b8, sum8;

`ifdef SHIFT_ADDER_VALID_EN
  logic valid1, valid4, valid2, valid8;
`endif

  shift_adder #(.W(16), .N(1)) u_n1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .sum(sum1)
`ifdef SHIFT_ADDER_VALID_EN
    , .valid(valid1)
`endif
  );

  shift_adder #(.W(16), .N(4)) u_n4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .sum(sum4)
`ifdef SHIFT_ADDER_VALID_EN
    , .valid(valid4)
`endif
  );

  shift_adder #(.W(16), .N(2)) u_n2 (
    .clk(clk), .rst(rst2), .a(a2), .b(b2), .sum(sum2)
`ifdef SHIFT_ADDER_VALID_EN
    , .valid(valid2)
`endif
  );

  shift_adder #(.W(8), .N(8)) u_s1 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .sum(sum8)
`ifdef SHIFT_ADDER_VALID_EN
    , .valid(valid8)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs driven and outputs sampled 1ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] bexp;
    logic [15:0] ra, rb, pa, pb, rexp;

    rst1 = 1'b1; rst4 = 1'b1; rst2 = 1'b1; rst8 = 1'b1;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0; a2 = '0; b2 = '0; a8 = '0; b8 = '0;
    tick(2);

    // Reset state: zero operands, zero carries
    chk("rst_sum_n1", sum1, 16'h0000);
    chk("rst_sum_n4", sum4, 16'h0000);
    chk("rst_sum_n2", sum2, 16'h0000);
    chk("rst_sum_s1", {8'h00, sum8}, 16'h0000);
`ifdef SHIFT_ADDER_VALID_EN
    chk("rst_valid_n4", {15'h0, valid4}, 16'h0000);
`endif

    // N=4: FFFF + 0001 held across reset release, carry ripples 3 edges
    a4 = 16'hFFFF; b4 = 16'h0001;
    tick(1);
    rst4 = 1'b0;
    #1;
    chk("n4_cyc0", sum4, 16'hFFF0);
    tick(1);
    chk("n4_edge1", sum4, 16'hFF00);
`ifdef SHIFT_ADDER_VALID_EN
    chk("n4_valid_e1", {15'h0, valid4}, 16'h0000);
`endif
    tick(1);
    chk("n4_edge2", sum4, 16'hF000);
    tick(1);
    chk("n4_edge3", sum4, 16'h0000);
`ifdef SHIFT_ADDER_VALID_EN
    chk("n4_valid_e3", {15'h0, valid4}, 16'h0000);
`endif
    tick(1);
    chk("n4_hold", sum4, 16'h0000);
`ifdef SHIFT_ADDER_VALID_EN
    chk("n4_valid_e4", {15'h0, valid4}, 16'h0001);
`endif

    // Stale carries (all three set) flush within one edge for 1234+4321
    a4 = 16'h1234; b4 = 16'h4321;
    #1;
    chk("n4_stale", sum4, 16'h6665);
    tick(1);
    chk("n4_flushed", sum4, 16'h5555);

    // No cross-segment carries from clean state: correct same cycle
    rst4 = 1'b1;
    a4 = 16'h0000; b4 = 16'h0000;
    tick(1);
    rst4 = 1'b0;
    a4 = 16'h1234; b4 = 16'h4321;
    #1;
    chk("n4_nocarry", sum4, 16'h5555);
    tick(1);
    chk("n4_nocarry_hold", sum4, 16'h5555);

    // S=1: purely combinational, reset has no effect on sum
    rst8 = 1'b0;
    a8 = 8'd200; b8 = 8'd100;
    #1;
    chk("s1_sum", {8'h00, sum8}, 16'd44);
    rst8 = 1'b1;
    #1;
    chk("s1_rst_comb", {8'h00, sum8}, 16'd44);
    tick(1);
    chk("s1_rst_edge", {8'h00, sum8}, 16'd44);
    rst8 = 1'b0;
    a8 = 8'd255; b8 = 8'd1;
    #1;
    chk("s1_wrap", {8'h00, sum8}, 16'd0);

    // N=1 reset mid-settle: FFFF+1, reset on edge 5
    rst1 = 1'b0;
    a1 = 16'hFFFF; b1 = 16'h0001;
    #1;
    chk("mid_cyc0", sum1, 16'hFFFE);
    tick(4);
    chk("mid_edge4", sum1, 16'hFFE0);
    rst1 = 1'b1;
    #1;
`ifdef SHIFT_ADDER_VALID_EN
    chk("mid_valid_rst", {15'h0, valid1}, 16'h0000);
`endif
    tick(1);
    rst1 = 1'b0;
    #1;
    chk("mid_cleared", sum1, 16'hFFFE);
    tick(14);
    chk("mid_edge14", sum1, 16'h8000);
    tick(1);
    chk("mid_edge15", sum1, 16'h0000);
`ifdef SHIFT_ADDER_VALID_EN
    chk("mid_valid_e15", {15'h0, valid1}, 16'h0000);
    tick(1);
    chk("mid_valid_e16", {15'h0, valid1}, 16'h0001);
`endif

    // N=2: 1000 random vectors held 8 edges, sum checked at edges 7 and 8
    rst2 = 1'b0;
    pa = '0; pb = '0;
    for (int v = 0; v < 1000; v++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ({ra, rb} == {pa, pb}) ra = ra ^ 16'h0001;
      pa = ra; pb = rb;
      rexp = ra + rb;
      a2 = ra; b2 = rb;
      tick(7);
      chk("n2_edge7", sum2, rexp);
`ifdef SHIFT_ADDER_VALID_EN
      chk("n2_valid_e7", {15'h0, valid2}, 16'h0000);
`endif
      tick(1);
      chk("n2_edge8", sum2, rexp);
`ifdef SHIFT_ADDER_VALID_EN
      chk("n2_valid_e8", {15'h0, valid2}, 16'h0001);
`endif
    end

    // N=1 accumulator: a=32, b <- sum every 16 cycles, wraps after 2048
    rst1 = 1'b1;
    a1 = 16'd32; b1 = 16'd0;
    tick(1);
    rst1 = 1'b0;
    bexp = 16'd0;
    for (int p = 1; p <= 2050; p++) begin
      tick(16);
      bexp = bexp + 16'd32;
      chk("acc", sum1, bexp);
      b1 = sum1;
      if (p == 2048) chk("acc_wrap", b1, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
